// File: rtl/kulisch_acc_pipe.sv
// Two-stage exact dot-product accumulator: S1 forms the shifted two's-complement term,
// S2 sums it modulo 2^ACC_WIDTH and emits the result (with sticky overflow) on the last beat.
module kulisch_acc_pipe #(
   parameter int  EXP_IN_A  = 3,
   parameter int  FRAC_IN_A = 2,
   parameter int  EXP_IN_B  = 3,
   parameter int  FRAC_IN_B = 2,
   parameter int  ACC_WIDTH = 32,
   localparam int MW = FRAC_IN_A + FRAC_IN_B + 2,
   localparam int EW = ((EXP_IN_A > EXP_IN_B) ? EXP_IN_A : EXP_IN_B) + 1
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MW-1:0]        man_ab,
   input  logic [EW-1:0]        exp_ab,
   input  logic                 sign_ab,
   input  logic                 in_last,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic                 out_overflow
);

   // Wide enough that no bit of the largest shift is ever lost before the overflow test.
   localparam int XW = ACC_WIDTH + (1 << EW);

   generate
      if (ACC_WIDTH < MW + 1) begin : g_bad_width
         $error("kulisch_acc_pipe: ACC_WIDTH must be at least MW+1");
      end
   endgenerate

   logic [MW:0]          w_mag;
   logic [MW:0]          w_sval;
   logic [XW-1:0]        w_ext;
   logic [XW-1:0]        w_shift;
   logic                 w_neg;
   logic [ACC_WIDTH-1:0] w_term;
   logic                 w_term_ovf;

   assign w_mag   = {1'b0, man_ab};
   assign w_sval  = sign_ab ? -w_mag : w_mag;
   assign w_ext   = {{(XW-MW-1){w_sval[MW]}}, w_sval};
   assign w_shift = w_ext << exp_ab;
   assign w_neg   = sign_ab && (man_ab != '0);
   assign w_term  = w_shift[ACC_WIDTH-1:0];
   // Every bit from the kept MSB upward must equal the true sign, else the term did not fit.
   assign w_term_ovf = |(w_shift[XW-1:ACC_WIDTH-1] ^ {(XW-ACC_WIDTH+1){w_neg}});

   logic                 r_s1_vld, r_s1_tovf, r_s1_last;
   logic [ACC_WIDTH-1:0] r_s1_term;
   logic                 r_s2_vld, r_s2_tovf, r_s2_last;
   logic [ACC_WIDTH-1:0] r_s2_term;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic                 r_out_vld;
   logic [ACC_WIDTH-1:0] r_out_acc;
   logic                 r_out_ovf;

   logic [ACC_WIDTH-1:0] w_sum;
   logic                 w_add_ovf;
   logic                 w_ovf_nxt;
   logic                 w_stall;
   logic                 w_accept;
   logic                 w_load;

   assign w_sum     = r_acc + r_s2_term;
   assign w_add_ovf = (r_acc[ACC_WIDTH-1] == r_s2_term[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
   assign w_ovf_nxt = r_ovf | r_s2_tovf | w_add_ovf;

   // Only a finished dot product blocked behind an unconsumed result stops the pipe.
   assign w_stall  = r_out_vld && !out_ready && r_s2_vld && r_s2_last;
   assign w_accept = in_valid && !w_stall;
   assign w_load   = r_s2_vld && r_s2_last && !w_stall && !clear;

   assign in_ready     = !w_stall;
   assign out_valid    = r_out_vld;
   assign out_acc      = r_out_acc;
   assign out_overflow = r_out_ovf;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_s1_vld  <= 1'b0;
         r_s1_tovf <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_term <= '0;
         r_s2_vld  <= 1'b0;
         r_s2_tovf <= 1'b0;
         r_s2_last <= 1'b0;
         r_s2_term <= '0;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_out_vld <= 1'b0;
         r_out_acc <= '0;
         r_out_ovf <= 1'b0;
      end else begin
         // clear kills both in-flight beats so no part of the aborted sum survives
         if (clear) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
         end else if (!w_stall) begin
            r_s1_vld  <= w_accept;
            r_s1_term <= w_term;
            r_s1_tovf <= w_term_ovf;
            r_s1_last <= in_last;
            r_s2_vld  <= r_s1_vld;
            r_s2_term <= r_s1_term;
            r_s2_tovf <= r_s1_tovf;
            r_s2_last <= r_s1_last;
            if (r_s2_vld) begin
               r_acc <= r_s2_last ? '0 : w_sum;
               r_ovf <= r_s2_last ? 1'b0 : w_ovf_nxt;
            end
         end

         if (w_load) begin
            r_out_vld <= 1'b1;
            r_out_acc <= w_sum;
            r_out_ovf <= w_ovf_nxt;
         end else if (out_ready) begin
            r_out_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kulisch_acc_pipe.sv
// Bench for kulisch_acc_pipe: directed cases plus random traffic scored against an
// arithmetic model of the dot product (exact integer terms, range tests for overflow).
module tb_kulisch_acc_pipe;

   localparam int EA = 3, FA = 2, EB = 3, FB = 2;
   localparam int W  = 16;
   localparam int MW = FA + FB + 2;
   localparam int EW = ((EA > EB) ? EA : EB) + 1;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [MW-1:0] man_ab = '0;
   logic [EW-1:0] exp_ab = '0;
   logic          sign_ab = 1'b0;
   logic          in_last = 1'b0;
   logic          clear = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_acc;
   logic          out_overflow;

   kulisch_acc_pipe #(
      .EXP_IN_A(EA), .FRAC_IN_A(FA), .EXP_IN_B(EB), .FRAC_IN_B(FB), .ACC_WIDTH(W)
   ) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .man_ab(man_ab), .exp_ab(exp_ab), .sign_ab(sign_ab), .in_last(in_last),
      .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_overflow(out_overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] acc;
      logic         ovf;
   } res_t;

   res_t   exp_q[$];
   longint m_acc = 0;
   bit     m_ovf = 1'b0;
   int     n_chk = 0;
   int     n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic longint wrapv(input longint x);
      longint m;
      longint r;
      m = longint'(1) << W;
      r = x % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   function automatic bit fits(input longint x);
      return (x >= -(longint'(1) << (W-1))) && (x < (longint'(1) << (W-1)));
   endfunction

   // Scoreboard: model updates on each accepted beat, results checked at each handshake.
   logic         prev_hold = 1'b0;
   logic [W-1:0] prev_acc = '0;
   logic         prev_ovf = 1'b0;

   always @(negedge clock) begin : mon
      res_t   e;
      longint v;
      longint s;
      if (!resetn) begin
         exp_q.delete();
         m_acc     = 0;
         m_ovf     = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_acc", out_acc, prev_acc);
            chk("hold_ovf", out_overflow, prev_ovf);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_result", out_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("res_acc", out_acc, e.acc);
               chk("res_ovf", out_overflow, e.ovf);
            end
         end
         if (clear) begin
            m_acc = 0;
            m_ovf = 1'b0;
         end else if (in_valid && in_ready) begin
            v = longint'(man_ab) * (longint'(1) << exp_ab);
            if (sign_ab) v = -v;
            s = m_acc + wrapv(v);
            m_ovf = m_ovf | !fits(v) | !fits(s);
            m_acc = wrapv(s);
            if (in_last) begin
               e.acc = m_acc[W-1:0];
               e.ovf = m_ovf;
               exp_q.push_back(e);
               m_acc = 0;
               m_ovf = 1'b0;
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_acc  = out_acc;
         prev_ovf  = out_overflow;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send(input int m, input int e, input bit s, input bit l);
      man_ab   = MW'(m);
      exp_ab   = EW'(e);
      sign_ab  = s;
      in_last  = l;
      in_valid = 1'b1;
      @(negedge clock);
      for (int n = 0; n < 50 && !in_ready; n++) @(negedge clock);
      if (!in_ready) chk("send_ready", in_ready, 1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc", out_acc, 0);
      chk("rst_out_ovf", out_overflow, 0);
      resetn = 1'b1;
      chk("rst_in_ready", in_ready, 1);

      // single-beat result and its two-edge latency
      send(9, 2, 0, 1);
      @(negedge clock);
      @(negedge clock);
      chk("lat_early", out_valid, 0);
      @(negedge clock);
      chk("lat_valid", out_valid, 1);
      chk("one_term_acc", out_acc, 36);
      chk("one_term_ovf", out_overflow, 0);
      idle(2);

      // mixed signs, negated zero, then overflow and recovery
      send(9, 2, 0, 0);
      send(5, 0, 1, 1);
      send(0, 5, 1, 1);
      idle(4);
      send(63, 15, 0, 1);
      send(1, 0, 0, 1);
      idle(4);

      // backpressure: non-last beats flow, the next last beat stalls the pipe
      send(2, 0, 0, 1);
      out_ready = 1'b0;
      repeat (3) send(1, 0, 0, 0);
      send(1, 0, 0, 1);
      @(negedge clock);
      chk("bp_ready_flow", in_ready, 1);
      @(negedge clock);
      chk("bp_stall", in_ready, 0);
      chk("bp_held", out_acc, 2);
      idle(2);
      chk("bp_stall_hold", in_ready, 0);
      out_ready = 1'b1;
      @(negedge clock);
      chk("bp_first", out_acc, 2);
      @(negedge clock);
      chk("bp_second", out_acc, 4);
      chk("bp_valid_kept", out_valid, 1);
      idle(3);

      // clear drops the in-flight partial sum and the beat presented with it
      send(1, 0, 0, 0);
      in_valid = 1'b1; man_ab = MW'(2); exp_ab = '0; sign_ab = 1'b0; in_last = 1'b0;
      clear = 1'b1;
      idle(1);
      clear = 1'b0; in_valid = 1'b0;
      send(4, 0, 0, 1);
      idle(4);

      // clear beats a last beat sitting in S2: no result appears
      send(7, 0, 0, 1);
      idle(1);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      void'(exp_q.pop_back());
      idle(3);
      chk("clr_no_result", out_valid, 0);
      send(3, 0, 0, 1);
      idle(4);

      // a held result survives clear
      out_ready = 1'b0;
      send(5, 0, 0, 1);
      idle(3);
      chk("held_valid", out_valid, 1);
      in_valid = 1'b1; man_ab = MW'(6); exp_ab = '0; sign_ab = 1'b0; in_last = 1'b1;
      clear = 1'b1;
      idle(1);
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      idle(3);
      chk("clr_held_valid", out_valid, 1);
      chk("clr_held_acc", out_acc, 5);
      out_ready = 1'b1;
      idle(2);
      chk("clr_held_gone", out_valid, 0);

      // one-cycle reset mid-stream with a result still held
      out_ready = 1'b0;
      send(8, 0, 0, 1);
      idle(3);
      send(2, 0, 0, 0);
      send(3, 0, 0, 0);
      resetn = 1'b0;
      idle(1);
      resetn = 1'b1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_acc", out_acc, 0);
      chk("mid_rst_ovf", out_overflow, 0);
      chk("mid_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      send(3, 1, 0, 1);
      idle(2);
      @(negedge clock);
      chk("mid_rst_new_acc", out_acc, 6);
      idle(2);

      // random traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         man_ab    = ($urandom_range(7) == 0) ? '0 : MW'($urandom_range((1 << MW) - 1));
         exp_ab    = EW'($urandom_range((1 << EW) - 1));
         sign_ab   = 1'($urandom_range(1));
         in_last   = ($urandom_range(3) == 0);
         out_ready = ($urandom_range(9) < 7);
         idle(1);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      idle(10);
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
